ps2_scancode_receiver: RTL and testbench
========================================

Name: ps2_scancode_receiver

Overview:
- Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data lines and validates start, odd parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into flags attached to the following code byte.
- Buffers complete scan codes in a small FIFO and presents them with a valid/ready handshake.
- Sits upstream of the character drawing path; its 8-bit code is the address that selects a glyph.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before an in-progress frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- ps2_clk  in  1  raw PS/2 clock from connector, asynchronous
- ps2_data  in  1  raw PS/2 data from connector, asynchronous
- code_ready  in  1  consumer accepts head entry
- code_valid  out  1  FIFO non-empty
- code  out  8  head entry scan code
- code_ext  out  1  head entry was preceded by E0
- code_break  out  1  head entry was preceded by F0
- parity_err  out  1  one-cycle pulse, bad parity
- frame_err  out  1  one-cycle pulse, bad stop bit or timeout
- overflow  out  1  one-cycle pulse, code dropped because FIFO full

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0; FIFO empty; FSM to IDLE; ext/brk flags cleared; timeout counter 0.
  - Synchroniser registers set to 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through 2 flops.
  - A falling edge is synced-previous 1 and synced-current 0.
  - All FSM actions occur only in a cycle where a falling edge is detected.
- FSM:
  - IDLE: data=0 goes to DATA with bit_cnt=0. data=1 is ignored; no error.
  - DATA: shift data into byte LSB-first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: evaluate the frame, go to IDLE.
- Frame check at STOP edge (cycle T):
  - If the XOR of the 8 data bits and the parity bit is 0: parity_err=1 in T+1.
  - Else if stop=0: frame_err=1 in T+1.
  - On either error: byte discarded, ext/brk flags cleared.
  - Parity error takes priority over stop error; only one pulse is issued.
- Timeout:
  - Counter clears on every falling edge and while in IDLE.
  - In any other state, reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE, pulses frame_err next cycle and clears the flags.
- Byte decode (good frame at cycle T):
  - 0xE0: set ext flag, no push.
  - 0xF0: set brk flag, no push.
  - Any other value: push {ext, brk, byte}, clear both flags.
  - Flags persist across frames until consumed or cleared.
- FIFO:
  - First-word-fall-through; push occurs at the end of T, so code_valid and the head fields are valid from T+1.
  - Pop at any clk edge where code_valid && code_ready.
  - Push with FIFO full and no simultaneous pop: entry dropped, overflow=1 for one cycle, contents unchanged.
  - Push with FIFO full and a simultaneous pop: both occur, no overflow.
  - Push into an empty FIFO with code_ready=1: not visible before T+1.
  - code, code_ext and code_break are held stable while code_valid=1 and there is no pop.
  - Read and write pointers wrap modulo DEPTH; the count width is log2(DEPTH)+1.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - A good frame with brk flag set clears both flags and is never pushed.
  - code_break is tied to 0.
  - Only make codes reach the consumer.
- Undefined: break codes are pushed with code_break=1, as described in Behaviour.

Test Plan:
- Frame 0x1C, parity 0, stop 1, code_ready=1 -> code_valid high for exactly 1 cycle from the cycle after STOP; code=0x1C, ext=0, break=0; no error pulses.
- Frames F0 then 1C -> macro undefined: one entry, code=0x1C, break=1, ext=0. Macro defined: no code_valid at all.
- Frames E0, F0, 75 -> macro undefined: one entry, code=0x75, ext=1, break=1. A following frame 0x75 gives ext=0, break=0.
- Frame 0x45 with parity bit 1 -> parity_err pulses 1 cycle, no entry. A following good 0x45 is received normally.
- DEPTH=4, code_ready=0, send 0x16, 0x1E, 0x26, 0x25, 0x2E -> overflow pulses on the 5th frame. Raising code_ready drains 16, 1E, 26, 25 in order, then code_valid=0.
- Start bit plus 5 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulses once. Next frame 0x16 gives code=0x16.
- Separately, asserting rst_n=0 mid-frame, then sending 0x16 -> code=0x16 with no stale data.

Source files
------------

// File: rtl/ps2_scancode_receiver_if.sv
// Scan-code delivery channel: FWFT head entry with a valid/ready handshake.
// The receiver drives the master side and the downstream glyph path the slave side.
interface ps2_scancode_receiver_if;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] code;
    logic       code_ext;
    logic       code_break;

    modport master (output code_valid, code, code_ext, code_break, input code_ready);
    modport slave  (input code_valid, code, code_ext, code_break, output code_ready);
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frame check, E0/F0 prefix folding and a FWFT scan-code FIFO.
// Define PS2_BREAK_FILTER_EN to drop break codes so only make codes reach the consumer.
module ps2_scancode_receiver #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    ps2_scancode_receiver_if.master       code_if,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_BREAK_FILTER_EN
    localparam int EW = 9;
`else
    localparam int EW = 10;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    // Synchronisers idle high like the bus so reset never fakes a falling edge
    logic kclk_s1_q, kclk_s2_q, kclk_prev_q;
    logic kdat_s1_q, kdat_s2_q;
    logic fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdat_s1_q   <= 1'b1;
            kdat_s2_q   <= 1'b1;
        end else begin
            kclk_s1_q   <= ps2_clk;
            kclk_s2_q   <= kclk_s1_q;
            kclk_prev_q <= kclk_s2_q;
            kdat_s1_q   <= ps2_data;
            kdat_s2_q   <= kdat_s1_q;
        end
    end

    assign fall = kclk_prev_q & ~kclk_s2_q;

    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic            perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic            push_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        push_req  = 1'b0;
        to_cnt_d  = (state_q == IDLE) ? '0 : to_cnt_q + 1'b1;

        if (fall) begin
            to_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!kdat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {kdat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = kdat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    // Odd parity: data bits plus parity bit must XOR to 1
                    if (!(^shift_q ^ par_q)) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (!kdat_s2_q) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
`ifdef PS2_BREAK_FILTER_EN
                        push_req = !brk_q;
`else
                        push_req = 1'b1;
`endif
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = IDLE;
            to_cnt_d = '0;
            ferr_d   = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
        end
    end

    // FWFT FIFO; a full FIFO still accepts a push when the head pops in the same cycle
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [EW-1:0] push_data, head;
    logic          full, pop, do_push, valid;

`ifdef PS2_BREAK_FILTER_EN
    assign push_data = {ext_q, shift_q};
`else
    assign push_data = {ext_q, brk_q, shift_q};
`endif

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = valid & code_if.code_ready;
    assign do_push = push_req & (~full | pop);
    assign ovf_d   = push_req & full & ~pop;
    assign head    = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(pop);
        end
    end

    assign code_if.code_valid = valid;
    assign code_if.code       = valid ? head[7:0] : 8'h00;
    assign code_if.code_ext   = valid & head[EW-1];
`ifdef PS2_BREAK_FILTER_EN
    assign code_if.code_break = 1'b0;
`else
    assign code_if.code_break = valid & head[8];
`endif

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Bench for ps2_scancode_receiver: vector table of frames plus hand sequences for
// latency, overflow, timeout and mid-frame reset; popped entries checked against a queue.
module tb_ps2_scancode_receiver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic parity_err, frame_err, overflow;

    ps2_scancode_receiver_if cif ();

    ps2_scancode_receiver #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_if    (cif.master),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_perr;
        bit         exp_ferr;
        bit         exp_push;
        bit         exp_ext;
        bit         exp_brk;
    } vec_t;

    vec_t       vecs [15];
    logic [9:0] exp_q [$];
    int checks = 0, failures = 0;
    int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Counts pulse cycles and compares every popped entry against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) perr_cnt++;
            if (frame_err)  ferr_cnt++;
            if (overflow)   ovf_cnt++;
            if (cif.code_valid && cif.code_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected got=%0h expected=none",
                             {cif.code_ext, cif.code_break, cif.code});
                end else begin
                    chk("pop_entry", {22'd0, cif.code_ext, cif.code_break, cif.code},
                        {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input bit ext, input bit brk, input logic [7:0] d);
`ifdef PS2_BREAK_FILTER_EN
        if (!brk) exp_q.push_back({ext, 1'b0, d});
`else
        exp_q.push_back({ext, brk, d});
`endif
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int p0, f0, o0;

        vecs[0]  = '{8'h1C, 0, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{8'hF0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{8'h1C, 0, 0, 0, 0, 1, 0, 1};
        vecs[3]  = '{8'hE0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{8'hF0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{8'h75, 0, 0, 0, 0, 1, 1, 1};
        vecs[6]  = '{8'h75, 0, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{8'h45, 1, 0, 1, 0, 0, 0, 0};
        vecs[8]  = '{8'h45, 0, 0, 0, 0, 1, 0, 0};
        vecs[9]  = '{8'hE0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{8'h33, 0, 1, 0, 1, 0, 0, 0};
        vecs[11] = '{8'h33, 0, 0, 0, 0, 1, 0, 0};
        vecs[12] = '{8'hF0, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{8'h12, 1, 1, 1, 0, 0, 0, 0};
        vecs[14] = '{8'h12, 0, 0, 0, 0, 1, 0, 0};

        cif.code_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_outputs", {cif.code_valid, cif.code, cif.code_ext, cif.code_break,
                              parity_err, frame_err, overflow}, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // First-entry latency: visible exactly two cycles after the STOP edge is seen
        expect_push(1'b0, 1'b0, 8'h1C);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(vecs[0].data[i]);
        send_bit(~^vecs[0].data);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("latency_not_early", cif.code_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_valid", cif.code_valid, 1);
        chk("latency_code", cif.code, 8'h1C);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wait_drain("latency_drain");

        for (int v = 0; v < 15; v++) begin
            p0 = perr_cnt;
            f0 = ferr_cnt;
            if (vecs[v].exp_push) expect_push(vecs[v].exp_ext, vecs[v].exp_brk, vecs[v].data);
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop);
            chk($sformatf("vec%0d_perr", v), perr_cnt - p0, {31'd0, vecs[v].exp_perr});
            chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, {31'd0, vecs[v].exp_ferr});
            wait_drain($sformatf("vec%0d_drain", v));
        end

        // Overflow: four fill the FIFO, the fifth is dropped
        cif.code_ready = 1'b0;
        o0 = ovf_cnt;
        expect_push(1'b0, 1'b0, 8'h16);
        expect_push(1'b0, 1'b0, 8'h1E);
        expect_push(1'b0, 1'b0, 8'h26);
        expect_push(1'b0, 1'b0, 8'h25);
        send_frame(8'h16, 0, 0);
        send_frame(8'h1E, 0, 0);
        send_frame(8'h26, 0, 0);
        send_frame(8'h25, 0, 0);
        chk("ovf_none_before", ovf_cnt - o0, 0);
        chk("ovf_head_held", cif.code, 8'h16);
        send_frame(8'h2E, 0, 0);
        chk("ovf_pulse", ovf_cnt - o0, 1);
        cif.code_ready = 1'b1;
        wait_drain("ovf_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_empty", cif.code_valid, 0);

        // Timeout on a stalled frame, then normal reception resumes
        f0 = ferr_cnt;
        p0 = perr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (TIMEOUT + 20) @(posedge clk);
        #1;
        chk("timeout_ferr", ferr_cnt - f0, 1);
        chk("timeout_no_perr", perr_cnt - p0, 0);
        expect_push(1'b0, 1'b0, 8'h16);
        send_frame(8'h16, 0, 0);
        wait_drain("timeout_recover");

        // Reset mid-frame discards the partial byte
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_outputs", {cif.code_valid, parity_err, frame_err, overflow}, 0);
        rst_n = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        expect_push(1'b0, 1'b0, 8'h16);
        send_frame(8'h16, 0, 0);
        wait_drain("midreset_recover");
        chk("midreset_errs", (ferr_cnt - f0) + (perr_cnt - p0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
